// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared RV32I decode constants.
package decode_queue_pkg;
    localparam int kInstructionWidth = 32;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

// File: rtl/decode_queue_imm_gen.sv
// imm_gen: RV32I immediate extraction, sign-extended to XLEN.
module imm_gen
    import decode_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [kInstructionWidth-1:0] i_inst,
    output logic [XLEN-1:0]              o_imm
);
    logic [6:0]  w_op;
    logic [31:0] w_imm;
    assign w_op = i_inst[6:0];
    always_comb begin
        w_imm = (w_op == OP_LOAD || w_op == OP_IMM || w_op == OP_JALR) ? {{20{i_inst[31]}}, i_inst[31:20]}
              : (w_op == OP_STORE)  ? {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]}
              : (w_op == OP_BRANCH) ? {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}
              : (w_op == OP_LUI || w_op == OP_AUIPC) ? {i_inst[31:12], 12'b0}
              : (w_op == OP_JAL)    ? {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}
              : '0;
    end
    assign o_imm = XLEN'($signed(w_imm));
endmodule

// File: rtl/decode_queue.sv
// decode_queue: registered instruction FIFO with combinational field decode of the head.
// Define DECODE_QUEUE_IMM_EN to generate out_imm; otherwise out_imm is tied to 0.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_W-1:0]          in_inst,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [2:0]                 out_funct3,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [6:0]                 out_funct7,
    output logic [INST_W-1:0]          out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic [XLEN-1:0]            out_imm,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [INST_W-1:0] r_inst [DEPTH];
    logic [PC_W-1:0]   r_pc   [DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_full, w_push, w_pop;
    assign w_full    = r_count == CW'(DEPTH);
    assign in_ready  = !w_full;
    assign out_valid = r_count != '0;
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign count     = r_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    // Storage is unreset: every output is gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_wptr] <= in_inst;
            r_pc[r_wptr]   <= in_pc;
        end
    end
    assign out_inst   = out_valid ? r_inst[r_rptr] : '0;
    assign out_pc     = out_valid ? r_pc[r_rptr] : '0;
    assign out_opcode = out_inst[6:0];
    assign out_rd     = out_inst[11:7];
    assign out_funct3 = out_inst[14:12];
    assign out_rs1    = out_inst[19:15];
    assign out_rs2    = out_inst[24:20];
    assign out_funct7 = out_inst[31:25];
`ifdef DECODE_QUEUE_IMM_EN
    logic [XLEN-1:0] w_imm;
    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_inst (out_inst[kInstructionWidth-1:0]),
        .o_imm  (w_imm)
    );
    assign out_imm = w_imm;
`else
    assign out_imm = '0;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: random and directed checks of decode_queue against a queue-based model.
module tb_decode_queue;
    localparam int D  = 2;
    localparam int CW = $clog2(D) + 1;
    logic clk = 0, reset = 1, in_valid = 0, flush = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [31:0] in_inst = 0, in_pc = 0, out_inst, out_pc, out_imm;
    logic [6:0] out_opcode, out_funct7;
    logic [4:0] out_rd, out_rs1, out_rs2;
    logic [2:0] out_funct3;
    logic [CW-1:0] count;
    int checks = 0, failures = 0;
    bit cmp_en = 0;

    decode_queue #(.DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct7(out_funct7), .out_inst(out_inst), .out_pc(out_pc),
        .out_imm(out_imm), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    ent_t mq[$];
    bit m_pu, m_po;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] x);
        int sx, hi, v;
        sx = $signed(x);
        v = 0;
        case (x[6:0])
            7'h03, 7'h13, 7'h67: v = sx >>> 20;
            7'h23: begin hi = sx >>> 25; v = hi * 32 + int'(x[11:7]); end
            7'h63: begin hi = sx >>> 31; v = hi * 4096 + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2; end
            7'h37, 7'h17: v = sx & 32'hFFFFF000;
            7'h6F: begin hi = sx >>> 31; v = hi * 1048576 + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2; end
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] x);
`ifdef DECODE_QUEUE_IMM_EN
        return ref_imm(x);
`else
        return (x == x) ? 32'h0 : 32'h0;
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset || flush) mq.delete();
        else begin
            m_pu = in_valid && mq.size() < D;
            m_po = out_ready && mq.size() > 0;
            if (m_po) void'(mq.pop_front());
            if (m_pu) mq.push_back('{in_inst, in_pc});
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] ei, ep;
            logic ev;
            ev = mq.size() > 0;
            ei = ev ? mq[0].inst : 32'h0;
            ep = ev ? mq[0].pc : 32'h0;
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < D));
            chk("count", 64'(count), 64'(mq.size()));
            chk("out_inst", 64'(out_inst), 64'(ei));
            chk("out_pc", 64'(out_pc), 64'(ep));
            chk("fields", {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}, 64'(ei));
            chk("out_imm", 64'(out_imm), 64'(ev ? exp_imm(ei) : 32'h0));
        end
    end

    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic ordy, input logic fl);
        @(negedge clk);
        #2;
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin
        logic [31:0] r;
        repeat (2) @(posedge clk);
        cyc(0, 0, 0, 0, 0);
        reset = 0;
        cmp_en = 1;
        tick();
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_ready", 64'(in_ready), 1);
        chk("rst_count", 64'(count), 0);
        // addi x1, x0, 5
        cyc(1, 32'h00500093, 0, 0, 0);
        tick();
        chk("addi_valid", 64'(out_valid), 1);
        chk("addi_rd", 64'(out_rd), 1);
        chk("addi_rs1", 64'(out_rs1), 0);
        chk("addi_f3", 64'(out_funct3), 0);
        chk("addi_count", 64'(count), 1);
`ifdef DECODE_QUEUE_IMM_EN
        chk("addi_imm", 64'(out_imm), 5);
`else
        chk("addi_imm", 64'(out_imm), 0);
`endif
        cyc(0, 0, 0, 1, 0);
        tick();
        chk("pop_count", 64'(count), 0);
        for (int i = 0; i < D; i++) begin
            cyc(1, 32'h1000 + 32'(i), 32'(4 * i), 0, 0);
            tick();
        end
        cyc(1, 32'hDEAD, 32'h99, 0, 0);
        tick();
        chk("full_ready", 64'(in_ready), 0);
        chk("full_count", 64'(count), D);
        for (int i = 0; i < D; i++) begin
            chk("order", 64'(out_inst), 64'(32'h1000 + 32'(i)));
            cyc(0, 0, 0, 1, 0);
            tick();
        end
        chk("drained", 64'(count), 0);
        for (int i = 0; i < D; i++) begin
            cyc(1, 32'h2000 + 32'(i), 0, 0, 0);
            tick();
        end
        cyc(1, 32'hBEEF, 0, 1, 0);
        tick();
        chk("fullpp_count", 64'(count), D - 1);
        chk("fullpp_head", 64'(out_inst), 32'h2001);
        cyc(1, 32'h3000, 0, 0, 0);
        tick();
        chk("two_count", 64'(count), 2);
        cyc(1, 32'h4000, 0, 1, 1);
        tick();
        chk("flush_count", 64'(count), 0);
        chk("flush_valid", 64'(out_valid), 0);
        chk("flush_inst", 64'(out_inst), 0);
        chk("flush_imm", 64'(out_imm), 0);
        cyc(1, 32'hFE000EE3, 32'h40, 0, 0);
        tick();
`ifdef DECODE_QUEUE_IMM_EN
        chk("beq_imm", 64'(out_imm), 32'hFFFFFFFC);
`else
        chk("beq_imm", 64'(out_imm), 0);
`endif
        chk("ref_beq", 64'(ref_imm(32'hFE000EE3)), 32'hFFFFFFFC);
        chk("ref_lui", 64'(ref_imm(32'hABCDE0B7)), 32'hABCDE000);
        cyc(0, 0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("arst_valid", 64'(out_valid), 0);
        chk("arst_count", 64'(count), 0);
        chk("arst_ready", 64'(in_ready), 1);
        #1 reset = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom();
            cyc($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 9)]}, $urandom(),
                $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        cyc(0, 0, 0, 0, 0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter INST_W, default 32, instruction width in bits (fixed at 32 for RV32I decode).
REQ-002 SHALL have parameter PC_W, default 32, width of the PC carried with each instruction.
REQ-003 SHALL have parameter XLEN, default 32, width of the sign-extended immediate.
REQ-004 SHALL have parameter DEPTH, default 2, queue entries; power of two, 2..16.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  in  1  fetch offers an instruction.
REQ-008 SHALL have port in_ready  out  1  queue accepts; equals !full.
REQ-009 SHALL have ports in_inst  in  INST_W and in_pc  in  PC_W  fetched word and its PC.
REQ-010 SHALL have port flush  in  1  discard all queued entries (branch mispredict).
REQ-011 SHALL have port out_valid  out  1  head entry present.
REQ-012 SHALL have port out_ready  in  1  execute side consumes head.
REQ-013 SHALL have ports out_opcode 7, out_rd 5, out_funct3 3, out_rs1 5, out_rs2 5, out_funct7 7  out  decoded head fields (bits 6:0, 11:7, 14:12, 19:15, 24:20, 31:25).
REQ-014 SHALL have ports out_inst  out  INST_W, out_pc  out  PC_W, out_imm  out  XLEN.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-017 SHALL present a pushed entry on the outputs no earlier than the cycle after the push edge (no fall-through bypass).
REQ-018 SHALL support simultaneous push and pop when neither full nor empty, with count unchanged.
REQ-019 SHALL, when full, deassert in_ready; a pop in that cycle SHALL NOT enable a same-cycle push.
REQ-020 SHALL, when empty, deassert out_valid and ignore out_ready.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; full/empty SHALL be derived from count.
REQ-022 SHALL, on flush, set count and both pointers to 0 at the next edge; push and pop in that cycle SHALL be discarded.
REQ-023 SHALL drive all out_* data fields to 0 whenever out_valid is 0.
REQ-024 SHALL decode fields combinationally from the head entry; opcode-independent fields SHALL be raw bit slices.
REQ-025 SHALL never change count by more than 1 per cycle.

Reset
REQ-026 SHALL, on reset assertion, asynchronously clear count and both pointers; in_ready=1, out_valid=0, all data outputs 0.
REQ-027 SHALL, with reset asserted mid-transfer, drop every queued entry; no entry SHALL survive reset.
REQ-028 Storage array SHALL NOT require reset (outputs gated by REQ-023).

Configuration
REQ-029 Macro DECODE_QUEUE_IMM_EN SHALL control immediate generation.
REQ-030 With DECODE_QUEUE_IMM_EN defined, out_imm SHALL be the sign-extended immediate by opcode: I (0000011, 0010011, 1100111), S (0100011), B (1100011, bit0=0), U (0110111, 0010111, low 12 bits 0), J (1101111, bit0=0); any other opcode -> 0.
REQ-031 Without DECODE_QUEUE_IMM_EN, out_imm SHALL be constant 0 and no immediate logic SHALL be instantiated.

Structure
REQ-032 Opcode constants (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL) SHALL live in the shared constants package alongside kInstructionWidth.
REQ-033 Immediate generation SHALL be a sub-module named imm_gen (in: instruction; out: XLEN immediate), instantiated only under DECODE_QUEUE_IMM_EN.

Verification
REQ-034 Reset, then push 0x00500093 at PC 0x0 -> next cycle out_valid=1, out_rd=1, out_rs1=0, out_funct3=0, out_imm=5 (IMM_EN), count=1.
REQ-035 Push DEPTH entries without pop -> in_ready=0, count=DEPTH; extra in_valid ignored; pop order equals push order.
REQ-036 Full queue, out_ready=1 and in_valid=1 same cycle -> one pop, no push, count=DEPTH-1.
REQ-037 Two entries queued, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, all out fields 0.
REQ-038 Head 0xFE000EE3 (BEQ, offset -4) -> out_imm=0xFFFFFFFC with IMM_EN, 0 without.
REQ-039 Reset asserted asynchronously between edges with 1 entry queued -> out_valid falls immediately, count=0, in_ready=1.
